// File: rtl/cam_capture_downscale_if.sv
// Camera pin bundle plus the decimated pixel stream toward the frame buffer.
// master drives the camera side and enable; slave is the capture block.
interface cam_capture_downscale_if #(parameter int bitsPixel = 8);
  logic                 i_enable;
  logic                 cam_pclk;
  logic                 cam_href;
  logic                 cam_vsync;
  logic [7:0]           cam_data;
  logic                 o_DV;
  logic [bitsPixel-1:0] o_pixel;
  logic                 o_frameDone;
  logic                 o_frameErr;
  logic                 o_capturing;

  modport master (
    output i_enable, cam_pclk, cam_href, cam_vsync, cam_data,
    input  o_DV, o_pixel, o_frameDone, o_frameErr, o_capturing
  );

  modport slave (
    input  i_enable, cam_pclk, cam_href, cam_vsync, cam_data,
    output o_DV, o_pixel, o_frameDone, o_frameErr, o_capturing
  );
endinterface

// File: rtl/cam_capture_downscale.sv
// RGB565 camera capture, packed to RGB332 and decimated 2:1 in x and y.
// Latency: o_DV 3 clk after the raw pclk edge of the low byte; no backpressure.
module cam_capture_downscale #(
  parameter int bitsPixel = 8,
  parameter int hActive   = 640,
  parameter int vActive   = 480,
  parameter int numPixel  = (hActive / 2) * (vActive / 2)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cam_capture_downscale_if.slave  bus
);
  localparam logic [9:0]  H_ACT = 10'(hActive);
  localparam logic [9:0]  V_ACT = 10'(vActive);
  localparam logic [16:0] N_PIX = 17'(numPixel);

  typedef enum logic [1:0] {WAIT_VSYNC, WAIT_FRAME, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [2:0]           pclk_sync, vsync_sync, href_sync;
  logic [7:0]           data_s1, data_s2;
  logic [5:0]           hi_bits;
  logic                 phase;
  logic [9:0]           col, row;
  logic [16:0]          count;
  logic                 dv, frame_done, frame_err;
  logic [bitsPixel-1:0] pixel;
  logic                 pclk_rise, vs_rise, vs_fall, href_fall;
  logic                 frame_start, frame_end, take;

  // Index [1] is the synchronized value, [2] its previous cycle for edges.
  assign pclk_rise = pclk_sync[1] & ~pclk_sync[2];
  assign vs_rise   = vsync_sync[1] & ~vsync_sync[2];
  assign vs_fall   = ~vsync_sync[1] & vsync_sync[2];
  assign href_fall = ~href_sync[1] & href_sync[2];
  assign take      = (col < H_ACT) && (row < V_ACT) && !col[0] && !row[0] && (count < N_PIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_sync  <= '0;
      vsync_sync <= '0;
      href_sync  <= '0;
      data_s1    <= '0;
      data_s2    <= '0;
    end else begin
      pclk_sync  <= {pclk_sync[1:0], bus.cam_pclk};
      vsync_sync <= {vsync_sync[1:0], bus.cam_vsync};
      href_sync  <= {href_sync[1:0], bus.cam_href};
      data_s1    <= bus.cam_data;
      data_s2    <= data_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_VSYNC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      WAIT_VSYNC: if (vs_rise) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (vs_fall) begin
        if (bus.i_enable) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end else begin
          state_nxt = WAIT_VSYNC;
        end
      end
      ACTIVE: if (vs_rise) begin
        state_nxt = WAIT_FRAME;
        frame_end = 1'b1;
      end
      default: state_nxt = WAIT_VSYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_bits    <= '0;
      phase      <= 1'b0;
      col        <= '0;
      row        <= '0;
      count      <= '0;
      dv         <= 1'b0;
      pixel      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      dv         <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (frame_start) begin
        col   <= '0;
        row   <= '0;
        phase <= 1'b0;
        count <= '0;
      end else if (frame_end) begin
        // A pclk edge landing with the vsync edge is dropped here.
        frame_done <= 1'b1;
        frame_err  <= (count != N_PIX);
      end else if (state == ACTIVE) begin
        if (href_fall) begin
          col   <= '0;
          phase <= 1'b0;
          if (row < V_ACT) row <= row + 10'd1;
        end else if (pclk_rise && href_sync[1]) begin
          if (!phase) begin
            hi_bits <= {data_s2[7:5], data_s2[2:0]};
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (col != '1) col <= col + 10'd1;
            if (take) begin
              dv    <= 1'b1;
              pixel <= bitsPixel'({hi_bits, data_s2[4:3]});
              count <= count + 17'd1;
            end
          end
        end
      end
    end
  end

  assign bus.o_DV        = dv;
  assign bus.o_pixel     = pixel;
  assign bus.o_frameDone = frame_done;
  assign bus.o_frameErr  = frame_err;
  assign bus.o_capturing = (state == ACTIVE);
endmodule
